// File: rtl/counter_driver_pkg.sv
// Shared types and defaults for the counter_driver command sequencer.
package counter_driver_pkg;

    localparam int unsigned DEF_SIZE  = 4;
    localparam int unsigned DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        OP_WAIT   = 2'd0,
        OP_LOAD   = 2'd1,
        OP_RUN_UP = 2'd2,
        OP_RUN_DN = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/counter_driver_evcnt.sv
// Saturating event counter with synchronous clear (priority) and increment enable.
module counter_driver_evcnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over increment; count sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/counter_driver.sv
// Command-driven sequencer for the counter control interface.
// Optional macro COUNTER_DRIVER_HOLD_EN adds a 'hold' input that stalls RUN/WAIT.
module counter_driver
    import counter_driver_pkg::*;
#(
    parameter int unsigned SIZE  = DEF_SIZE,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [SIZE-1:0]  cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             enable,
    output logic             preload,
    output logic [SIZE-1:0]  preload_data,
    output logic             mode,
    input  logic             detect,
    input  logic [SIZE-1:0]  result,
`ifdef COUNTER_DRIVER_HOLD_EN
    input  logic             hold,
`endif
    output logic             done,
    output logic [SIZE-1:0]  last_result,
    output logic [LEN_W-1:0] detect_count
);

    state_e           state, state_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic             tick, tick_nxt;
    logic             enable_nxt, preload_nxt, mode_nxt, done_nxt;
    logic [SIZE-1:0]  preload_data_nxt, last_result_nxt;
    logic             hold_i;
    logic             accept;
    op_e              op;

`ifdef COUNTER_DRIVER_HOLD_EN
    assign hold_i = hold;
`else
    assign hold_i = 1'b0;
`endif

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign op        = op_e'(cmd_op);

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            tick         <= 1'b0;
            enable       <= 1'b0;
            preload      <= 1'b0;
            preload_data <= '0;
            mode         <= 1'b0;
            done         <= 1'b0;
            last_result  <= '0;
        end else begin
            state        <= state_nxt;
            remaining    <= remaining_nxt;
            tick         <= tick_nxt;
            enable       <= enable_nxt;
            preload      <= preload_nxt;
            preload_data <= preload_data_nxt;
            mode         <= mode_nxt;
            done         <= done_nxt;
            last_result  <= last_result_nxt;
        end
    end

    // Next-state and next-output decode. 'tick' marks a cycle that consumes
    // one unit of len; hold clears it so the stalled cycle is not counted.
    always_comb begin
        state_nxt        = state;
        remaining_nxt    = remaining;
        tick_nxt         = 1'b0;
        preload_nxt      = 1'b0;
        preload_data_nxt = preload_data;
        mode_nxt         = mode;
        done_nxt         = 1'b0;
        last_result_nxt  = last_result;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    remaining_nxt = cmd_len;
                    unique case (op)
                        OP_LOAD: begin
                            state_nxt        = ST_LOAD;
                            preload_nxt      = 1'b1;
                            preload_data_nxt = cmd_data;
                        end
                        OP_RUN_UP, OP_RUN_DN: begin
                            if (cmd_len != '0) begin
                                state_nxt = ST_RUN;
                                tick_nxt  = 1'b1;
                                mode_nxt  = (op == OP_RUN_UP);
                            end else begin
                                state_nxt = ST_DONE;
                                done_nxt  = 1'b1;
                            end
                        end
                        OP_WAIT: begin
                            if (cmd_len != '0) begin
                                state_nxt = ST_WAIT;
                                tick_nxt  = 1'b1;
                            end else begin
                                state_nxt = ST_DONE;
                                done_nxt  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
            end
            ST_RUN, ST_WAIT: begin
                if (tick && (remaining == LEN_W'(1))) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    if (tick)
                        remaining_nxt = remaining - LEN_W'(1);
                    tick_nxt = !hold_i;
                end
            end
            ST_DONE: begin
                state_nxt       = ST_IDLE;
                last_result_nxt = result;
            end
            default: state_nxt = ST_IDLE;
        endcase

        enable_nxt = tick_nxt && (state_nxt == ST_RUN);
    end

    // Detect events are counted in RUN and in DONE to absorb the counter's
    // one-cycle registered lag.
    counter_driver_evcnt #(
        .W (LEN_W)
    ) u_evcnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   (detect && ((state == ST_RUN) || (state == ST_DONE))),
        .count (detect_count)
    );

endmodule

// File: doc/counter_driver.md
Name: counter_driver

Overview:
- Hardware initiator for the counter control interface (enable/preload/preload_data/mode in, detect/result back).
- Replaces hand-driven stimulus with a command-driven sequencer. Accepts one command at a time over a valid/ready handshake and executes it against the counter.
- Returns the completion status, the final counter result and a count of detect events.
- Sits between a host/test controller and a counter instance of matching SIZE.

Parameters:
- SIZE, 4, width of preload_data/result (must match the attached counter)
- LEN_W, 8, width of command length field and of detect_count

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  2  0=WAIT, 1=LOAD, 2=RUN_UP, 3=RUN_DN
- cmd_data  input  SIZE  preload value, used by LOAD only
- cmd_len  input  LEN_W  cycle count for WAIT/RUN_*
- enable  output  1  counter enable
- preload  output  1  counter preload strobe
- preload_data  output  SIZE  counter preload value
- mode  output  1  counter direction: 1=up, 0=down
- detect  input  1  counter detect flag
- result  input  SIZE  counter value
- done  output  1  one-cycle pulse at command completion
- last_result  output  SIZE  result sampled in the DONE cycle
- detect_count  output  LEN_W  detect cycles seen during the current/last command; saturating

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; enable, preload, mode, done = 0; preload_data, last_result, detect_count, remaining = 0. cmd_ready = 1 once reset is released.
- States: IDLE, LOAD, RUN, WAIT, DONE. All outputs are registered except cmd_ready, which equals (state==IDLE).
- IDLE: on cmd_valid&&cmd_ready, latch op/data/len into registers and clear detect_count to 0. Next state by op:
  - LOAD → LOAD
  - RUN_UP/RUN_DN with len>0 → RUN
  - WAIT with len>0 → WAIT
  - any op with len==0, except LOAD → DONE
- LOAD: exactly one cycle with preload=1 and preload_data=cmd_data; enable=0. Then DONE.
- RUN: enable=1 for exactly len consecutive cycles; mode=1 for RUN_UP, 0 for RUN_DN; preload=0. remaining loads len and decrements each cycle; on remaining==1 go to DONE.
- WAIT: enable=0, preload=0 for len cycles, then DONE.
- DONE: one cycle; done=1; last_result<=result; then IDLE. cmd_ready=0 in DONE, so back-to-back commands have a minimum one idle-accept cycle between them.
- mode holds its last value outside RUN; reset value is 0.
- detect_count: increments on each cycle with detect=1 while state is RUN or DONE. The DONE cycle is included to cover the counter's registered one-cycle lag. It saturates at all-ones and holds its value until the next command is accepted.
- cmd_valid while busy: ignored, no back-pressure violation; the host holds the command until cmd_ready.
- Reset mid-command: outputs drop immediately; no done pulse; the in-flight command is discarded.

Optional Feature:
- Macro: COUNTER_DRIVER_HOLD_EN.
- Defined:
  - Adds input port hold (1 bit).
  - While hold=1 in RUN or WAIT: enable=0, remaining frozen, no state change.
  - Execution resumes when hold=0, so total active enable cycles still equal len.
  - hold is ignored in IDLE/LOAD/DONE.
- Undefined: no hold port; RUN/WAIT are never stalled.

Decomposition:
- Package counter_driver_pkg holds:
  - op enum type (OP_WAIT, OP_LOAD, OP_RUN_UP, OP_RUN_DN)
  - state enum type
  - default SIZE/LEN_W localparams
- One natural sub-module: counter_driver_evcnt, a saturating LEN_W-bit event counter with synchronous clear and increment-enable, used for detect_count.

Test Plan:
- Reset hold 3 cycles, then release → cmd_ready=1; enable/preload/done/detect_count=0.
- LOAD cmd_data=4'hA accepted at cycle T → preload=1, preload_data=4'hA at T+1 only; done at T+2; last_result=4'hA.
- LOAD 0 then RUN_UP len=5 → enable=1, mode=1 for exactly 5 cycles; done; last_result=4'h5.
- LOAD 1 then RUN_DN len=3, with the bench driving detect=1 for 2 cycles in RUN → result wraps to 4'hE; last_result=4'hE; detect_count=2.
- RUN_UP len=0 → enable never asserted; done one cycle after accept; detect_count=0.
- RUN_UP len=10 with reset pulled low on the 4th enable cycle → enable=0 in the same cycle; no done pulse; cmd_ready=1 after release.
